// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the master engine, address decoder and read-data mux.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } mst_state_t;

endpackage

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite master: turns core commands into one NONSEQ transfer each,
// with wait states, two-cycle ERROR, RETRY/SPLIT reissue and a data-phase hang timeout.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic [1:0]        hresp
);

  localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  // The abort fires on the wait edge that would bring the count up to TIMEOUT_CYCLES.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [RC_W-1:0] RC_MAX  = RC_W'(MAX_RETRY);

  mst_state_t        state_q;
  logic [ADDR_W-1:0] haddr_q;
  logic [1:0]        htrans_q;
  logic              hwrite_q;
  logic [DATA_W-1:0] hwdata_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;
  logic [RC_W-1:0]   retry_cnt_q;
  logic [TO_W-1:0]   timeout_cnt_q;
  hresp_t            resp_s;

  assign resp_s = hresp_t'(hresp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      haddr_q       <= '0;
      htrans_q      <= HTRANS_IDLE;
      hwrite_q      <= 1'b0;
      hwdata_q      <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      retry_cnt_q   <= '0;
      timeout_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking default makes rsp_valid a one-cycle pulse; later assignments
      // in this block override it without any ordering hazard between registers.
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            haddr_q       <= cmd_addr;
            hwrite_q      <= cmd_write;
            wdata_q       <= cmd_wdata;
            retry_cnt_q   <= '0;
            timeout_cnt_q <= '0;
            htrans_q      <= HTRANS_NONSEQ;
            state_q       <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          htrans_q      <= HTRANS_IDLE;
          hwdata_q      <= hwrite_q ? wdata_q : '0;
          timeout_cnt_q <= '0;
          state_q       <= ST_DATA;
        end
        ST_DATA: begin
          if (hready) begin
            case (resp_s)
              HRESP_OKAY: begin
                rsp_valid_q   <= 1'b1;
                rsp_err_q     <= 1'b0;
                rsp_timeout_q <= 1'b0;
                rsp_rdata_q   <= hwrite_q ? '0 : hrdata;
                state_q       <= ST_IDLE;
              end
              HRESP_ERROR: begin
                rsp_valid_q   <= 1'b1;
                rsp_err_q     <= 1'b1;
                rsp_timeout_q <= 1'b0;
                rsp_rdata_q   <= '0;
                state_q       <= ST_IDLE;
              end
              default: begin
                // RETRY and SPLIT both reissue the same address/data until the budget runs out.
                if (retry_cnt_q < RC_MAX) begin
                  retry_cnt_q   <= retry_cnt_q + 1'b1;
                  timeout_cnt_q <= '0;
                  htrans_q      <= HTRANS_NONSEQ;
                  state_q       <= ST_ADDR;
                end else begin
                  rsp_valid_q   <= 1'b1;
                  rsp_err_q     <= 1'b1;
                  rsp_timeout_q <= 1'b0;
                  rsp_rdata_q   <= '0;
                  state_q       <= ST_IDLE;
                end
              end
            endcase
          end else if ((TIMEOUT_CYCLES > 0) && (timeout_cnt_q == TO_LAST)) begin
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
            state_q       <= ST_IDLE;
          end else if (timeout_cnt_q != '1) begin
            timeout_cnt_q <= timeout_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign haddr       = haddr_q;
  assign htrans      = htrans_q;
  assign hwrite      = hwrite_q;
  assign hsize       = HSIZE_WORD;
  assign hwdata      = hwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: scripted slave beats, scoreboard of expected responses.
module tb_ahb_lite_master;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;

  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, hwrite;
  logic [31:0] rsp_rdata, haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;

  logic        cmd_ready_z, rsp_valid_z, rsp_err_z, rsp_timeout_z, hwrite_z;
  logic [31:0] rsp_rdata_z, haddr_z, hwdata_z;
  logic [1:0]  htrans_z;
  logic [2:0]  hsize_z;

  always #5 clk = ~clk;

  ahb_lite_master #(.ADDR_W(32), .DATA_W(32), .MAX_RETRY(3), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  ahb_lite_master #(.ADDR_W(32), .DATA_W(32), .MAX_RETRY(3), .TIMEOUT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_z),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_z), .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z), .rsp_timeout(rsp_timeout_z),
    .haddr(haddr_z), .htrans(htrans_z), .hwrite(hwrite_z), .hsize(hsize_z), .hwdata(hwdata_z),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  // Which instance the transaction driver follows.
  logic sel_z = 1'b0;
  wire        m_cmd_ready   = sel_z ? cmd_ready_z   : cmd_ready;
  wire        m_rsp_valid   = sel_z ? rsp_valid_z   : rsp_valid;
  wire [31:0] m_rsp_rdata   = sel_z ? rsp_rdata_z   : rsp_rdata;
  wire        m_rsp_err     = sel_z ? rsp_err_z     : rsp_err;
  wire        m_rsp_timeout = sel_z ? rsp_timeout_z : rsp_timeout;
  wire [31:0] m_haddr       = sel_z ? haddr_z       : haddr;
  wire [1:0]  m_htrans      = sel_z ? htrans_z      : htrans;
  wire        m_hwrite      = sel_z ? hwrite_z      : hwrite;
  wire [31:0] m_hwdata      = sel_z ? hwdata_z      : hwdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          lat;
    int          phases;
  } exp_t;

  typedef struct packed {
    logic       rdy;
    logic [1:0] resp;
  } beat_t;

  exp_t  sb[$];
  beat_t script[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input int n, input logic rdy, input logic [1:0] r);
    beat_t b;
    b.rdy  = rdy;
    b.resp = r;
    for (int i = 0; i < n; i++) script.push_back(b);
  endtask

  task automatic expect_rsp(input logic [31:0] rdata, input logic err, input logic to,
                            input int lat, input int phases);
    exp_t e;
    e.rdata = rdata; e.err = err; e.to = to; e.lat = lat; e.phases = phases;
    sb.push_back(e);
  endtask

  // Issue one command, play the scripted slave beats in the data phase(s), then score the response.
  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int budget);
    exp_t  e;
    beat_t b;
    int    lat = 0;
    int    ph = 0;
    bit    in_data = 0;
    bit    first = 0;
    bit    done = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; hrdata = rdata;
    tick();
    cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    while (!done && lat < budget) begin
      if (m_rsp_valid) begin
        done = 1;
      end else begin
        if (m_htrans == HTRANS_NONSEQ) begin
          ph++;
          check("addr_phase_haddr", m_haddr, addr);
          check("addr_phase_hwrite", m_hwrite, wr);
          hready = 1'b1; hresp = HRESP_OKAY;
          in_data = 1; first = 1;
        end else if (in_data) begin
          if (first) check("cmd_ready_busy", m_cmd_ready, 1'b0);
          first = 0;
          if (wr) check("hwdata_stable", m_hwdata, wdata);
          if (script.size() > 0) b = script.pop_front();
          else begin b.rdy = 1'b1; b.resp = HRESP_OKAY; end
          hready = b.rdy; hresp = b.resp;
          if (b.rdy) in_data = 0;
        end
        tick();
        lat++;
      end
    end
    script.delete();
    hready = 1'b1; hresp = HRESP_OKAY;
    check("rsp_seen_in_budget", done, 1'b1);
    if (done && sb.size() > 0) begin
      e = sb.pop_front();
      check("latency", lat, e.lat);
      check("addr_phases", ph, e.phases);
      check("rsp_err", m_rsp_err, e.err);
      check("rsp_timeout", m_rsp_timeout, e.to);
      if (!e.err) check("rsp_rdata", m_rsp_rdata, e.rdata);
      tick();
      check("rsp_valid_pulse", m_rsp_valid, 1'b0);
      check("rsp_err_hold", m_rsp_err, e.err);
      check("cmd_ready_idle", m_cmd_ready, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    hrdata = '0; hready = 1'b1; hresp = HRESP_OKAY;
    #1;
    check("rst_htrans", htrans, HTRANS_IDLE);
    check("rst_haddr", haddr, 0);
    check("rst_hwrite", hwrite, 0);
    check("rst_hwdata", hwdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("hsize_word", hsize, 3'b010);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Read, zero wait states.
    expect_rsp(32'hDEAD_BEEF, 0, 0, 2, 1);
    do_cmd(1'b0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 40);

    // Write with three wait states; hrdata noise must not reach rsp_rdata.
    push_beats(3, 1'b0, HRESP_OKAY);
    expect_rsp(32'h0, 0, 0, 5, 1);
    do_cmd(1'b1, 32'h0000_2000, 32'h1234_5678, 32'hCAFE_0000, 40);

    // Two-cycle ERROR response.
    push_beats(1, 1'b0, HRESP_ERROR);
    push_beats(1, 1'b1, HRESP_ERROR);
    expect_rsp(32'h0, 1, 0, 3, 1);
    do_cmd(1'b0, 32'h0000_3008, 32'h0, 32'h1111_1111, 40);

    // RETRY on every attempt: initial issue plus three reissues, then failure.
    push_beats(4, 1'b1, HRESP_RETRY);
    expect_rsp(32'h0, 1, 0, 8, 4);
    do_cmd(1'b1, 32'h0000_400C, 32'hA5A5_0001, 32'h0, 40);

    // RETRY, SPLIT, then OKAY.
    push_beats(1, 1'b1, HRESP_RETRY);
    push_beats(1, 1'b1, HRESP_SPLIT);
    push_beats(1, 1'b1, HRESP_OKAY);
    expect_rsp(32'h0BAD_F00D, 0, 0, 6, 3);
    do_cmd(1'b0, 32'h0000_5010, 32'h0, 32'h0BAD_F00D, 40);

    // Timeout after 8 wait edges.
    push_beats(12, 1'b0, HRESP_OKAY);
    expect_rsp(32'h0, 1, 1, 9, 1);
    do_cmd(1'b0, 32'h0000_6000, 32'h0, 32'h2222_2222, 40);

    // Ready on the very edge the timeout would fire: the response wins.
    push_beats(7, 1'b0, HRESP_OKAY);
    push_beats(1, 1'b1, HRESP_OKAY);
    expect_rsp(32'h0000_0077, 0, 0, 9, 1);
    do_cmd(1'b0, 32'h0000_6004, 32'h0, 32'h0000_0077, 40);

    // Timeout disabled: 20 wait states then OKAY.
    sel_z = 1'b1;
    push_beats(20, 1'b0, HRESP_OKAY);
    push_beats(1, 1'b1, HRESP_OKAY);
    expect_rsp(32'h5A5A_A5A5, 0, 0, 22, 1);
    do_cmd(1'b0, 32'h0000_7000, 32'h0, 32'h5A5A_A5A5, 60);
    sel_z = 1'b0;
    tick();

    // Reset asserted during a data-phase wait state.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_8000; cmd_wdata = 32'hFACE_0001;
    tick();
    cmd_valid = 1'b0;
    tick();
    hready = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    check("midrst_htrans", htrans, HTRANS_IDLE);
    check("midrst_haddr", haddr, 0);
    check("midrst_hwrite", hwrite, 0);
    check("midrst_hwdata", hwdata, 0);
    check("midrst_rsp_rdata", rsp_rdata, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    tick();
    check("midrst_no_rsp", rsp_valid, 0);
    hready = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_no_rsp", rsp_valid, 0);

    // Normal write after the reset.
    expect_rsp(32'h0, 0, 0, 2, 1);
    do_cmd(1'b1, 32'h0000_9000, 32'h0F0F_0F0F, 32'h0, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
